// File: rtl/btb_pkg.sv
// rtl/btb_pkg.sv - shared types, counter encodings and index/tag helpers for the branch target buffer
package btb_pkg;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    // Tag is kept right-justified in a full word so the struct is independent of ENTRIES.
    typedef struct packed {
        logic        valid;
        logic [31:0] tag;
        logic [31:0] target;
        logic [1:0]  ctr;
    } btb_entry_t;

    function automatic int btb_idx_w(input int entries);
        return $clog2(entries);
    endfunction

    function automatic int btb_tag_w(input int idx_w);
        return 30 - idx_w;
    endfunction

    function automatic logic [31:0] btb_tag(input logic [31:0] pc, input int idx_w);
        logic [31:0] mask;
        mask = (32'h1 << btb_tag_w(idx_w)) - 32'h1;
        return (pc >> (idx_w + 2)) & mask;
    endfunction

endpackage

// File: rtl/btb_sat_counter2.sv
// rtl/btb_sat_counter2.sv - next-state logic for a 2-bit saturating direction counter
module btb_sat_counter2
    import btb_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    input  logic       force_strong,
    output logic [1:0] ctr_next
);

    always_comb begin
        ctr_next = ctr;
        if (force_strong) begin
            ctr_next = CTR_ST;
        end else if (taken) begin
            if (ctr != CTR_ST) ctr_next = ctr + 2'd1;
        end else begin
            if (ctr != CTR_SNT) ctr_next = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_target_buffer.sv
// rtl/branch_target_buffer.sv - direct-mapped BTB with 2-bit direction counters, trained from EX
module branch_target_buffer
    import btb_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      pc_if,
    output logic             btb_hit_if,
    output logic             predicted_taken_if,
    output logic [31:0]      predicted_next_pc_if,
    input  logic             update_btb_ex,
    input  logic [31:0]      pc_ex,
    input  logic             ex_is_jump,
    input  logic             ex_branch_taken,
    input  logic [31:0]      jump_addr_ex,
    input  logic             modify_pc_ex,
    input  logic             flush_btb,
    output logic [CNT_W-1:0] update_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int IDX = btb_idx_w(ENTRIES);

    btb_entry_t table_q [ENTRIES];

    logic [IDX-1:0] lu_idx;
    btb_entry_t     lu_entry;

    always_comb begin
        lu_idx               = pc_if[IDX+1:2];
        lu_entry             = table_q[lu_idx];
        btb_hit_if           = lu_entry.valid && (lu_entry.tag == btb_tag(pc_if, IDX));
        predicted_taken_if   = btb_hit_if && lu_entry.ctr[1];
        predicted_next_pc_if = predicted_taken_if ? lu_entry.target : pc_if + 32'd4;
    end

    logic [IDX-1:0] up_idx;
    btb_entry_t     up_entry;
    btb_entry_t     up_new;
    logic           up_hit;
    logic           up_taken;
    logic           up_write;
    logic [1:0]     ctr_in;
    logic [1:0]     ctr_next;

    // A fresh allocation starts from weak-NT so one taken step lands on weak-T for branches.
    always_comb begin
        up_idx   = pc_ex[IDX+1:2];
        up_entry = table_q[up_idx];
        up_hit   = up_entry.valid && (up_entry.tag == btb_tag(pc_ex, IDX));
        up_taken = ex_is_jump || ex_branch_taken;
        up_write = up_hit || up_taken;
        ctr_in   = up_hit ? up_entry.ctr : CTR_WNT;
        up_new.valid  = 1'b1;
        up_new.tag    = btb_tag(pc_ex, IDX);
        up_new.target = up_taken ? jump_addr_ex : up_entry.target;
        up_new.ctr    = ctr_next;
    end

    btb_sat_counter2 u_ctr (
        .ctr          (ctr_in),
        .taken        (up_taken),
        .force_strong (ex_is_jump),
        .ctr_next     (ctr_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= '{valid: 1'b0, tag: 32'd0, target: 32'd0, ctr: CTR_WNT};
            end
            update_count     <= '0;
            mispredict_count <= '0;
        end else begin
            if (flush_btb) begin
                for (int i = 0; i < ENTRIES; i++) begin
                    table_q[i].valid <= 1'b0;
                end
            end else if (update_btb_ex && up_write) begin
                table_q[up_idx] <= up_new;
            end
            if (update_btb_ex) update_count <= update_count + 1'b1;
            if (update_btb_ex && modify_pc_ex) mispredict_count <= mispredict_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_target_buffer.sv
// tb/tb_branch_target_buffer.sv - scoreboard bench for branch_target_buffer
module tb_branch_target_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_if = '0;
    logic        btb_hit_if;
    logic        predicted_taken_if;
    logic [31:0] predicted_next_pc_if;
    logic        update_btb_ex = 1'b0;
    logic [31:0] pc_ex = '0;
    logic        ex_is_jump = 1'b0;
    logic        ex_branch_taken = 1'b0;
    logic [31:0] jump_addr_ex = '0;
    logic        modify_pc_ex = 1'b0;
    logic        flush_btb = 1'b0;
    logic [31:0] update_count;
    logic [31:0] mispredict_count;

    branch_target_buffer #(.ENTRIES(16), .CNT_W(32)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .pc_if                (pc_if),
        .btb_hit_if           (btb_hit_if),
        .predicted_taken_if   (predicted_taken_if),
        .predicted_next_pc_if (predicted_next_pc_if),
        .update_btb_ex        (update_btb_ex),
        .pc_ex                (pc_ex),
        .ex_is_jump           (ex_is_jump),
        .ex_branch_taken      (ex_branch_taken),
        .jump_addr_ex         (jump_addr_ex),
        .modify_pc_ex         (modify_pc_ex),
        .flush_btb            (flush_btb),
        .update_count         (update_count),
        .mispredict_count     (mispredict_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        hit;
        logic        taken;
        logic [31:0] npc;
    } exp_t;

    exp_t        sb_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_upd = 0;
    logic [31:0] exp_mis = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // kind: 0 none, 1 taken branch, 2 not-taken branch, 3 jump
    task automatic step(input string tag, input logic [31:0] pc, input int kind,
                        input logic [31:0] pex, input logic [31:0] tgt, input logic mod,
                        input logic flush, input logic e_hit, input logic e_taken,
                        input logic [31:0] e_npc);
        exp_t e;
        @(negedge clk);
        pc_if           = pc;
        update_btb_ex   = (kind != 0);
        pc_ex           = pex;
        ex_is_jump      = (kind == 3);
        ex_branch_taken = (kind == 1);
        jump_addr_ex    = tgt;
        modify_pc_ex    = mod;
        flush_btb       = flush;
        sb_q.push_back('{hit: e_hit, taken: e_taken, npc: e_npc});
        if (kind != 0) begin
            exp_upd = exp_upd + 1;
            if (mod) exp_mis = exp_mis + 1;
        end
        #2;
        e = sb_q.pop_front();
        check({tag, ".hit"}, {31'd0, btb_hit_if}, {31'd0, e.hit});
        check({tag, ".taken"}, {31'd0, predicted_taken_if}, {31'd0, e.taken});
        check({tag, ".npc"}, predicted_next_pc_if, e.npc);
        @(posedge clk);
        #1;
        update_btb_ex = 1'b0;
        flush_btb     = 1'b0;
        check({tag, ".upd_cnt"}, update_count, exp_upd);
        check({tag, ".mis_cnt"}, mispredict_count, exp_mis);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1);
    end

    initial begin
        #12;
        check("reset.upd_cnt", update_count, 32'd0);
        check("reset.mis_cnt", mispredict_count, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        step("lookup_100",  32'h100, 0, 0, 0, 0, 0, 0, 0, 32'h104);
        step("lookup_wrap", 32'hFFFFFFFC, 0, 0, 0, 0, 0, 0, 0, 32'h0);

        step("alloc_same",  32'h100, 1, 32'h100, 32'h80, 1, 0, 0, 0, 32'h104);
        step("alloc_next",  32'h100, 0, 0, 0, 0, 0, 1, 1, 32'h80);

        step("dec_1",       32'h100, 2, 32'h100, 32'h0, 0, 0, 1, 1, 32'h80);
        step("dec_2",       32'h100, 2, 32'h100, 32'h0, 1, 0, 1, 0, 32'h104);
        step("dec_sat",     32'h100, 2, 32'h100, 32'h0, 0, 0, 1, 0, 32'h104);
        step("inc_1",       32'h100, 1, 32'h100, 32'h80, 0, 0, 1, 0, 32'h104);
        step("inc_2",       32'h100, 1, 32'h100, 32'h80, 1, 0, 1, 0, 32'h104);
        step("inc_done",    32'h100, 0, 0, 0, 0, 0, 1, 1, 32'h80);

        step("alias_jal",   32'h140, 3, 32'h140, 32'h2000, 1, 0, 0, 0, 32'h144);
        step("alias_old",   32'h100, 0, 0, 0, 0, 0, 0, 0, 32'h104);
        step("sat_hi",      32'h140, 1, 32'h140, 32'h2000, 0, 0, 1, 1, 32'h2000);
        step("st_dec",      32'h140, 2, 32'h140, 32'h0, 0, 0, 1, 1, 32'h2000);
        step("wt_dec",      32'h140, 2, 32'h140, 32'h0, 0, 0, 1, 1, 32'h2000);
        step("wnt_look",    32'h140, 0, 0, 0, 0, 0, 1, 0, 32'h144);

        step("nt_miss_a",   32'h208, 2, 32'h208, 32'h900, 0, 0, 0, 0, 32'h20C);
        step("nt_miss_b",   32'h208, 2, 32'h208, 32'h900, 1, 0, 0, 0, 32'h20C);
        step("nt_miss_c",   32'h208, 0, 0, 0, 0, 0, 0, 0, 32'h20C);

        step("alloc_208",   32'h140, 1, 32'h208, 32'h400, 0, 0, 1, 0, 32'h144);
        step("look_208",    32'h208, 0, 0, 0, 0, 0, 1, 1, 32'h400);
        step("flush_upd",   32'h140, 1, 32'h300, 32'h500, 1, 1, 1, 0, 32'h144);
        step("flush_140",   32'h140, 0, 0, 0, 0, 0, 0, 0, 32'h144);
        step("flush_208",   32'h208, 0, 0, 0, 0, 0, 0, 0, 32'h20C);
        step("flush_300",   32'h300, 0, 0, 0, 0, 0, 0, 0, 32'h304);

        step("pre_rst",     32'h100, 3, 32'h100, 32'h80, 0, 0, 0, 0, 32'h104);
        step("pre_rst_hit", 32'h100, 0, 0, 0, 0, 0, 1, 1, 32'h80);

        @(negedge clk);
        pc_if           = 32'h100;
        update_btb_ex   = 1'b1;
        pc_ex           = 32'h208;
        ex_branch_taken = 1'b1;
        jump_addr_ex    = 32'h600;
        modify_pc_ex    = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("arst.upd_cnt", update_count, 32'd0);
        check("arst.mis_cnt", mispredict_count, 32'd0);
        check("arst.hit", {31'd0, btb_hit_if}, 32'd0);
        check("arst.npc", predicted_next_pc_if, 32'h104);
        @(negedge clk);
        update_btb_ex   = 1'b0;
        ex_branch_taken = 1'b0;
        modify_pc_ex    = 1'b0;
        rst             = 1'b0;
        exp_upd         = 0;
        exp_mis         = 0;

        step("post_rst_208", 32'h208, 0, 0, 0, 0, 0, 0, 0, 32'h20C);
        step("post_rst_upd", 32'h100, 1, 32'h100, 32'h80, 0, 0, 0, 0, 32'h104);
        step("post_rst_hit", 32'h100, 0, 0, 0, 0, 0, 1, 1, 32'h80);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
